reaction_timer: RTL and testbench

Core timing stage of the reaction-time tester, directly downstream of the random generator. A start request samples the generator's 16-bit `rand` word to get a random fore-period, then waits for it and lights the stimulus LED. It then measures the time until the player's button press in whole milliseconds. It also flags false starts and timeouts, pulses `rand_reload` so the generator advances, and hands the result to the display logic.

---
 rtl/reaction_timer_pkg.sv | 22 ++
 rtl/reaction_timer_ms_prescaler.sv | 35 +++
 rtl/reaction_timer.sv | 190 +++++++++++++++++++
 tb/tb_reaction_timer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// -----------------------------------------------------------------------------
// reaction_timer_pkg
// Shared definitions for the reaction-time tester timing stage.
//   state_e          : FSM state encoding (IDLE=0, WAIT=1, REACT=2, RESULT=3)
//   MS_W             : width of every millisecond quantity
//   DEF_TIMEOUT_MS   : default reaction limit in ms
//   DEF_MIN_DELAY_MS : default fixed part of the fore-period in ms
// -----------------------------------------------------------------------------
package reaction_timer_pkg;

  localparam int MS_W             = 14;
  localparam int DEF_TIMEOUT_MS   = 9999;
  localparam int DEF_MIN_DELAY_MS = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REACT  = 2'd2,
    RESULT = 2'd3
  } state_e;

endpackage

// File: rtl/reaction_timer_ms_prescaler.sv
// -----------------------------------------------------------------------------
// ms_prescaler
// Free-running divider producing a one-cycle tick every TPM clock cycles.
// Also used by the display refresh logic.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   clr  in  synchronous restart: count returns to 0 at the next edge
//   tick out high for one cycle while the count sits at TPM-1 (wrap point)
// -----------------------------------------------------------------------------
module ms_prescaler #(
  parameter int TPM = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TPM > 1) ? $clog2(TPM) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TPM - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// -----------------------------------------------------------------------------
// reaction_timer
// Timing stage of the reaction-time tester. A start request latches a random
// fore-period, waits it out, lights the stimulus LED and then measures the
// time to the player's button press in whole milliseconds. False starts and
// timeouts are flagged; rand_reload asks the generator for a fresh word.
//
// Optional feature macro: REACTION_TIMER_BEST_EN adds the best_ms output
// (minimum valid reaction time since reset).
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   start        in   one-cycle start request (ignored in WAIT and REACT)
//   btn          in   player button level, already synchronised/debounced
//   rand_word    in   16-bit random word ("rand" is a reserved word in SV)
//   rand_reload  out  one-cycle pulse: generator should advance
//   led          out  stimulus LED
//   busy         out  high in WAIT and REACT
//   done         out  one-cycle pulse on entry to RESULT
//   result_ms    out  measured reaction time in ms
//   false_start  out  button seen before the stimulus
//   timeout      out  no press within TIMEOUT_MS
//   dbg_state    out  current FSM state (state_e encoding)
//   best_ms      out  best valid result since reset (REACTION_TIMER_BEST_EN)
//
// Handshake: start is a fire-and-forget pulse with no ready; it is accepted
// only in IDLE/RESULT. done is a single-cycle pulse with result_ms and the
// flags valid in the same cycle and held until the next accepted start.
// -----------------------------------------------------------------------------
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int MIN_DELAY_MS = DEF_MIN_DELAY_MS,
  parameter int RAND_BITS    = 11,
  parameter int TIMEOUT_MS   = DEF_TIMEOUT_MS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            btn,
  input  logic [15:0]     rand_word,
  output logic            rand_reload,
  output logic            led,
  output logic            busy,
  output logic            done,
  output logic [MS_W-1:0] result_ms,
  output logic            false_start,
  output logic            timeout,
  output logic [1:0]      dbg_state
`ifdef REACTION_TIMER_BEST_EN
  ,
  output logic [MS_W-1:0] best_ms
`endif
);

  localparam int              TPM = CLK_HZ / 1000;
  localparam logic [MS_W-1:0] TMO = MS_W'(TIMEOUT_MS);

  state_e          state;
  logic            go;        // start accepted, WAIT entered at the next edge
  logic [MS_W-1:0] delay_ms;
  logic [MS_W-1:0] ms_cnt;
  logic            btn_q;     // btn sampled at each edge
  logic            btn_prev;  // btn_q one edge earlier, for edge detection
  logic            tick;
  logic            clr;
  logic            start_ok;
  logic            rise;
  logic            unused_rand;

  // Only the low RAND_BITS of the random word contribute to the fore-period.
  assign unused_rand = ^rand_word;

  assign dbg_state = state;
  assign start_ok  = start && !go && ((state == IDLE) || (state == RESULT));
  assign rise      = btn_q && !btn_prev;

  // Timebase restarts when a start is accepted (so the fore-period is counted
  // from that edge) and again when the stimulus lights.
  assign clr = start_ok || ((state == WAIT) && !btn_q && (ms_cnt == delay_ms));

  ms_prescaler #(
    .TPM (TPM)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  // Millisecond counter, saturating at the reaction limit.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ms_cnt <= '0;
    end else if (tick && (ms_cnt != TMO)) begin
      ms_cnt <= ms_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      go          <= 1'b0;
      delay_ms    <= '0;
      btn_q       <= 1'b0;
      btn_prev    <= 1'b0;
      rand_reload <= 1'b0;
      led         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_ms   <= '0;
      false_start <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      btn_q       <= btn;
      // A press held through WAIT is a false start, so btn_prev is always low
      // on entry to REACT and the edge detector starts out clear.
      btn_prev    <= btn_q;
      done        <= 1'b0;
      rand_reload <= 1'b0;

      if (start_ok) begin
        go       <= 1'b1;
        delay_ms <= MS_W'(MIN_DELAY_MS) + MS_W'(rand_word[RAND_BITS-1:0]);
      end

      case (state)
        IDLE, RESULT: begin
          if (go) begin
            go          <= 1'b0;
            state       <= WAIT;
            busy        <= 1'b1;
            rand_reload <= 1'b1;
            result_ms   <= '0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
          end
        end

        WAIT: begin
          // False start checked first: it wins over the fore-period expiring.
          if (btn_q) begin
            state       <= RESULT;
            false_start <= 1'b1;
            result_ms   <= '0;
            done        <= 1'b1;
            busy        <= 1'b0;
          end else if (ms_cnt == delay_ms) begin
            state <= REACT;
            led   <= 1'b1;
          end
        end

        REACT: begin
          // A press in the same cycle as the limit still counts as a press.
          if (rise) begin
            state     <= RESULT;
            result_ms <= ms_cnt;
            done      <= 1'b1;
            busy      <= 1'b0;
            led       <= 1'b0;
          end else if (ms_cnt == TMO) begin
            state     <= RESULT;
            timeout   <= 1'b1;
            result_ms <= TMO;
            done      <= 1'b1;
            busy      <= 1'b0;
            led       <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef REACTION_TIMER_BEST_EN
  // Updated on the edge that raises done for a genuine button press.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_ms <= 14'h3FFF;
    end else if ((state == REACT) && rise && (ms_cnt < best_ms)) begin
      best_ms <= ms_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer
// Directed bench for reaction_timer with TPM = 10, MIN_DELAY_MS = 5,
// RAND_BITS = 3, TIMEOUT_MS = 20. Edge k is the k-th rising clock edge;
// inputs change and outputs are sampled on the falling edge after edge k.
// Define REACTION_TIMER_BEST_EN for both files to exercise best_ms.
// -----------------------------------------------------------------------------
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        btn;
  logic [15:0] rand_word;
  logic        rand_reload;
  logic        led;
  logic        busy;
  logic        done;
  logic [13:0] result_ms;
  logic        false_start;
  logic        timeout;
  logic [1:0]  dbg_state;
`ifdef REACTION_TIMER_BEST_EN
  logic [13:0] best_ms;
`endif

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reaction_timer #(
    .CLK_HZ       (10_000),
    .MIN_DELAY_MS (5),
    .RAND_BITS    (3),
    .TIMEOUT_MS   (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .btn         (btn),
    .rand_word   (rand_word),
    .rand_reload (rand_reload),
    .led         (led),
    .busy        (busy),
    .done        (done),
    .result_ms   (result_ms),
    .false_start (false_start),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
`ifdef REACTION_TIMER_BEST_EN
    ,
    .best_ms     (best_ms)
`endif
  );

  // ---------------- driver tasks ----------------
  // Return on the falling edge that follows rising edge k.
  task automatic at_neg(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Make start (with rand word r) be sampled at edge s.
  task automatic do_start(input int s, input logic [15:0] r);
    at_neg(s - 1);
    rand_word = r;
    start     = 1'b1;
    at_neg(s);
    start     = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    at_neg(2);
    n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL reset_led: got %b want 0", led); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (rand_reload !== 1'b0) begin n_bad++; $display("FAIL reset_reload: got %b want 0", rand_reload); end
    n_cmp++; if (result_ms !== 14'd0) begin n_bad++; $display("FAIL reset_result: got %0d want 0", result_ms); end
    n_cmp++; if ({false_start, timeout} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {false_start, timeout}); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
`ifdef REACTION_TIMER_BEST_EN
    n_cmp++; if (best_ms !== 14'h3FFF) begin n_bad++; $display("FAIL reset_best: got %h want 3fff", best_ms); end
`endif
    rst = 1'b0;
  endtask

  // start at 100, rand 3 -> delay 8, led at 181, btn sampled at 256 -> 7 ms
  task automatic test_basic();
    do_start(100, 16'h0003);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_n: got %b want 0", busy); end
    at_neg(101);
    n_cmp++; if (rand_reload !== 1'b1) begin n_bad++; $display("FAIL basic_reload: got %b want 1", rand_reload); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    n_cmp++; if (dbg_state !== 2'd1) begin n_bad++; $display("FAIL basic_wait: got %0d want 1", dbg_state); end
    at_neg(102);
    n_cmp++; if (rand_reload !== 1'b0) begin n_bad++; $display("FAIL basic_reload_end: got %b want 0", rand_reload); end
    at_neg(180);
    n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL basic_led_early: got %b want 0", led); end
    at_neg(181);
    n_cmp++; if (led !== 1'b1) begin n_bad++; $display("FAIL basic_led_rise: got %b want 1", led); end
    n_cmp++; if (dbg_state !== 2'd2) begin n_bad++; $display("FAIL basic_react: got %0d want 2", dbg_state); end
    at_neg(255);
    btn = 1'b1;
    at_neg(256);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_early: got %b want 0", done); end
    at_neg(257);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (result_ms !== 14'd7) begin n_bad++; $display("FAIL basic_result: got %0d want 7", result_ms); end
    n_cmp++; if ({false_start, timeout} !== 2'b00) begin n_bad++; $display("FAIL basic_flags: got %b want 00", {false_start, timeout}); end
    n_cmp++; if ({busy, led} !== 2'b00) begin n_bad++; $display("FAIL basic_busy_led: got %b want 00", {busy, led}); end
    at_neg(258);
    btn = 1'b0;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    n_cmp++; if (result_ms !== 14'd7) begin n_bad++; $display("FAIL basic_hold: got %0d want 7", result_ms); end
  endtask

  task automatic test_false_start();
    int s;
    s = 300;
    do_start(s, 16'h0003);
    at_neg(s + 1);
    n_cmp++; if (result_ms !== 14'd0) begin n_bad++; $display("FAIL fs_clear: got %0d want 0", result_ms); end
    at_neg(s + 49);
    btn = 1'b1;
    at_neg(s + 50);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fs_busy: got %b want 1", busy); end
    at_neg(s + 51);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL fs_done: got %b want 1", done); end
    n_cmp++; if (false_start !== 1'b1) begin n_bad++; $display("FAIL fs_flag: got %b want 1", false_start); end
    n_cmp++; if (dbg_state !== 2'd3) begin n_bad++; $display("FAIL fs_state: got %0d want 3", dbg_state); end
    at_neg(s + 90);
    btn = 1'b0;
    n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL fs_led: got %b want 0", led); end
  endtask

  // rand 0 -> delay 5, led at s+51; counter hits 20 at E+200 -> done E+201
  task automatic test_timeout();
    int s, e;
    s = 500;
    e = s + 51;
    do_start(s, 16'h0000);
    at_neg(e - 1);
    n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL to_led_early: got %b want 0", led); end
    at_neg(e);
    n_cmp++; if (led !== 1'b1) begin n_bad++; $display("FAIL to_led: got %b want 1", led); end
    at_neg(e + 200);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL to_done_early: got %b want 0", done); end
    at_neg(e + 201);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL to_done: got %b want 1", done); end
    n_cmp++; if ({false_start, timeout} !== 2'b01) begin n_bad++; $display("FAIL to_flags: got %b want 01", {false_start, timeout}); end
    n_cmp++; if (result_ms !== 14'd20) begin n_bad++; $display("FAIL to_result: got %0d want 20", result_ms); end
  endtask

  // Button sampled on the edge the counter reaches the limit: press wins.
  task automatic test_timeout_tie();
    int s, e;
    s = 800;
    e = s + 51;
    do_start(s, 16'h0000);
    at_neg(e + 199);
    btn = 1'b1;
    at_neg(e + 201);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL tie_done: got %b want 1", done); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL tie_timeout: got %b want 0", timeout); end
    n_cmp++; if (result_ms !== 14'd20) begin n_bad++; $display("FAIL tie_result: got %0d want 20", result_ms); end
    at_neg(e + 202);
    btn = 1'b0;
  endtask

  // Button sampled on the edge the fore-period expires: false start wins.
  task automatic test_fs_priority();
    int s;
    s = 1100;
    do_start(s, 16'h0003);
    at_neg(s + 79);
    btn = 1'b1;
    at_neg(s + 81);
    n_cmp++; if ({done, false_start} !== 2'b11) begin n_bad++; $display("FAIL fsp_flags: got %b want 11", {done, false_start}); end
    n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL fsp_led: got %b want 0", led); end
    at_neg(s + 82);
    btn = 1'b0;
  endtask

  task automatic test_ignore_and_reset();
    int s;
    s = 1200;
    do_start(s, 16'h0001);   // delay 6 -> led at s+61
    do_start(s + 20, 16'h0007);
    at_neg(s + 21);
    n_cmp++; if (rand_reload !== 1'b0) begin n_bad++; $display("FAIL ign_reload: got %b want 0", rand_reload); end
    at_neg(s + 60);
    n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL ign_led_early: got %b want 0", led); end
    at_neg(s + 61);
    n_cmp++; if (led !== 1'b1) begin n_bad++; $display("FAIL ign_led: got %b want 1", led); end
    at_neg(s + 69);
    rst = 1'b1;
    at_neg(s + 70);
    rst = 1'b0;
    n_cmp++; if ({led, busy, done} !== 3'b000) begin n_bad++; $display("FAIL rst_outs: got %b want 000", {led, busy, done}); end
    n_cmp++; if (result_ms !== 14'd0) begin n_bad++; $display("FAIL rst_result: got %0d want 0", result_ms); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
`ifdef REACTION_TIMER_BEST_EN
    n_cmp++; if (best_ms !== 14'h3FFF) begin n_bad++; $display("FAIL rst_best: got %h want 3fff", best_ms); end
`endif
    at_neg(s + 80);
    n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL rst_led_stays: got %b want 0", led); end
  endtask

  // Trials: press after c cycles of stimulus, or a false start (c < 0).
  task automatic test_trials();
    int c_tab[6]   = '{75, 45, 95, -1, 9, 10};
    int r_tab[6]   = '{7, 4, 9, 0, 0, 1};
    int b_tab[6]   = '{7, 4, 4, 4, 0, 0};
    int s, e, d;
    for (int i = 0; i < 6; i++) begin
      s = 1300 + i * 250;
      e = s + 81;
      d = (c_tab[i] < 0) ? s + 41 : e + c_tab[i] + 1;
      do_start(s, 16'h0003);
      at_neg(d - 2);
      btn = 1'b1;
      at_neg(d);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL trial%0d_done: got %b want 1", i, done); end
      n_cmp++; if (result_ms !== 14'(r_tab[i])) begin n_bad++; $display("FAIL trial%0d_result: got %0d want %0d", i, result_ms, r_tab[i]); end
      n_cmp++; if (false_start !== (c_tab[i] < 0)) begin n_bad++; $display("FAIL trial%0d_fs: got %b want %b", i, false_start, c_tab[i] < 0); end
`ifdef REACTION_TIMER_BEST_EN
      n_cmp++; if (best_ms !== 14'(b_tab[i])) begin n_bad++; $display("FAIL trial%0d_best: got %0d want %0d", i, best_ms, b_tab[i]); end
`else
      if (b_tab[i] < 0) $display("note: bad table entry %0d", i);
`endif
      at_neg(d + 1);
      btn = 1'b0;
    end
  endtask

  task automatic test_btn_held();
    int s;
    s = 2800;
    at_neg(s - 5);
    btn = 1'b1;
    do_start(s, 16'h0005);
    at_neg(s + 1);
    n_cmp++; if ({busy, false_start} !== 2'b10) begin n_bad++; $display("FAIL held_wait: got %b want 10", {busy, false_start}); end
    at_neg(s + 2);
    n_cmp++; if ({done, false_start} !== 2'b11) begin n_bad++; $display("FAIL held_fs: got %b want 11", {done, false_start}); end
    n_cmp++; if (result_ms !== 14'd0) begin n_bad++; $display("FAIL held_result: got %0d want 0", result_ms); end
    btn = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    btn       = 1'b0;
    rand_word = 16'h0000;
    test_reset();
    test_basic();
    test_false_start();
    test_timeout();
    test_timeout_tie();
    test_fs_priority();
    test_ignore_and_reset();
    test_trials();
    test_btn_held();
    at_neg(cyc + 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
